// File: rtl/word_serializer.sv
// word_serializer: accepts a WORD_W word over valid/ready and emits its lanes one beat at a time.
module word_serializer #(
  parameter int WORD_W = 32,
  parameter int LANE_W = 8,
  parameter int MSB_FIRST = 1,
  localparam int LANES = WORD_W / LANE_W,
  localparam int LW = $clog2(LANES) + 1,
  localparam int IW = (LW > 1) ? LW - 1 : 1
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic [LW-1:0]     in_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANE_W-1:0] out_data,
  output logic [IW-1:0]     out_idx,
  output logic              out_last
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;
  logic [WORD_W-1:0] shreg;
  logic [LW-1:0] len, eff_len;
  logic take, adv;
  assign out_valid = state == SEND;
  assign adv = out_valid && out_ready;
  assign in_ready = !reset && (state == IDLE || (adv && out_last));
  assign take = in_valid && in_ready;
  assign eff_len = (in_len == '0 || in_len > LW'(LANES)) ? LW'(LANES) : in_len;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = take ? SEND : (adv && out_last) ? IDLE : state;
  end
  // shreg holds the lanes not yet emitted, aligned so the next one sits at the emitting end
  always_ff @(posedge clk)
    if (reset) begin
      shreg <= '0;
      len <= '0;
      out_data <= '0;
      out_idx <= '0;
      out_last <= 1'b0;
    end else if (take) begin
      shreg <= (MSB_FIRST != 0) ? in_data << LANE_W : in_data >> LANE_W;
      out_data <= (MSB_FIRST != 0) ? in_data[WORD_W-1 -: LANE_W] : in_data[LANE_W-1:0];
      out_idx <= '0;
      out_last <= eff_len == LW'(1);
      len <= eff_len;
    end else if (adv && !out_last) begin
      shreg <= (MSB_FIRST != 0) ? shreg << LANE_W : shreg >> LANE_W;
      out_data <= (MSB_FIRST != 0) ? shreg[WORD_W-1 -: LANE_W] : shreg[LANE_W-1:0];
      out_idx <= out_idx + 1'b1;
      out_last <= LW'(out_idx) + LW'(2) == len;
    end
endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: MSB-first and LSB-first instances on shared stimulus, checked against a lane-queue model.
module tb_word_serializer;
  logic clk, reset, in_valid, out_ready;
  logic [31:0] in_data;
  logic [2:0] in_len;
  logic in_ready_m, in_ready_l, out_valid_m, out_valid_l, out_last_m, out_last_l;
  logic [7:0] out_data_m, out_data_l;
  logic [1:0] out_idx_m, out_idx_l;
  int passed = 0, total = 0;

  word_serializer #(.MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_data(in_data), .in_len(in_len), .out_valid(out_valid_m), .out_ready(out_ready),
    .out_data(out_data_m), .out_idx(out_idx_m), .out_last(out_last_m));
  word_serializer #(.MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_l),
    .in_data(in_data), .in_len(in_len), .out_valid(out_valid_l), .out_ready(out_ready),
    .out_data(out_data_l), .out_idx(out_idx_l), .out_last(out_last_l));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: the lanes still to be emitted for the current word, in emission order
  logic [7:0] qm[$], ql[$];
  int pos = 0;
  logic [7:0] hm = 0, hl = 0;
  int hi = 0;
  logic hlast = 0;

  function automatic logic exp_ready();
    return !reset && (qm.size() == 0 || (qm.size() == 1 && out_ready));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      qm.delete(); ql.delete();
      pos = 0; hm = 0; hl = 0; hi = 0; hlast = 0;
    end else begin
      automatic logic acc = in_valid && exp_ready();
      automatic int n = (in_len == 0 || in_len > 4) ? 4 : int'(in_len);
      if (qm.size() > 0 && out_ready) begin
        hm = qm[0]; hl = ql[0]; hi = pos; hlast = qm.size() == 1;
        void'(qm.pop_front()); void'(ql.pop_front());
        pos++;
      end
      if (acc) begin
        for (int k = 0; k < n; k++) begin
          qm.push_back(in_data[31-8*k -: 8]);
          ql.push_back(in_data[8*k +: 8]);
        end
        pos = 0;
      end
    end
  end

  always @(negedge clk) begin
    automatic logic busy = qm.size() > 0;
    chk("m_in_ready", 32'(in_ready_m), 32'(exp_ready()));
    chk("l_in_ready", 32'(in_ready_l), 32'(exp_ready()));
    chk("m_out_valid", 32'(out_valid_m), 32'(busy));
    chk("l_out_valid", 32'(out_valid_l), 32'(busy));
    chk("m_out_data", 32'(out_data_m), 32'(busy ? qm[0] : hm));
    chk("l_out_data", 32'(out_data_l), 32'(busy ? ql[0] : hl));
    chk("m_out_idx", 32'(out_idx_m), busy ? 32'(pos) : 32'(hi));
    chk("l_out_idx", 32'(out_idx_l), busy ? 32'(pos) : 32'(hi));
    chk("m_out_last", 32'(out_last_m), 32'(busy ? qm.size() == 1 : hlast));
    chk("l_out_last", 32'(out_last_l), 32'(busy ? ql.size() == 1 : hlast));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [2:0] l);
    in_valid = 1; in_data = d; in_len = l;
    cyc();
    in_valid = 0;
  endtask

  task automatic beat(input string nm, input logic [7:0] dm, input logic [7:0] dl, input int i, input logic l);
    @(negedge clk);
    chk({nm, "_valid"}, 32'(out_valid_m), 1);
    chk({nm, "_msb"}, 32'(out_data_m), 32'(dm));
    chk({nm, "_lsb"}, 32'(out_data_l), 32'(dl));
    chk({nm, "_idx"}, 32'(out_idx_m), 32'(i));
    chk({nm, "_last"}, 32'(out_last_m), 32'(l));
    chk({nm, "_in_ready"}, 32'(in_ready_m), 32'(l));
    cyc();
  endtask

  task automatic idle_chk(input string nm, input logic [7:0] dm, input int i, input logic l);
    @(negedge clk);
    chk({nm, "_valid"}, 32'(out_valid_m), 0);
    chk({nm, "_data"}, 32'(out_data_m), 32'(dm));
    chk({nm, "_idx"}, 32'(out_idx_m), 32'(i));
    chk({nm, "_last"}, 32'(out_last_m), 32'(l));
    chk({nm, "_in_ready"}, 32'(in_ready_m), 32'(!reset));
  endtask

  initial begin
    reset = 1; in_valid = 0; in_data = 0; in_len = 0; out_ready = 1;
    cyc(); cyc();
    idle_chk("rst", 8'h00, 0, 0);
    reset = 0;
    idle_chk("post_rst", 8'h00, 0, 0);
    cyc();
    send(32'h12345678, 4);
    beat("w1b0", 8'h12, 8'h78, 0, 0);
    beat("w1b1", 8'h34, 8'h56, 1, 0);
    beat("w1b2", 8'h56, 8'h34, 2, 0);
    beat("w1b3", 8'h78, 8'h12, 3, 1);
    idle_chk("w1_hold", 8'h78, 3, 1);
    cyc();
    send(32'hA1B2C3D4, 0);
    beat("w2b0", 8'hA1, 8'hD4, 0, 0);
    beat("w2b1", 8'hB2, 8'hC3, 1, 0);
    beat("w2b2", 8'hC3, 8'hB2, 2, 0);
    beat("w2b3", 8'hD4, 8'hA1, 3, 1);
    send(32'hDEADBEEF, 2);
    beat("len2b0", 8'hDE, 8'hEF, 0, 0);
    beat("len2b1", 8'hAD, 8'hBE, 1, 1);
    idle_chk("len2_done", 8'hAD, 1, 1);
    cyc();
    send(32'hDEADBEEF, 7);
    beat("len7b0", 8'hDE, 8'hEF, 0, 0);
    beat("len7b1", 8'hAD, 8'hBE, 1, 0);
    beat("len7b2", 8'hBE, 8'hAD, 2, 0);
    beat("len7b3", 8'hEF, 8'hDE, 3, 1);
    in_valid = 1; in_data = 32'h01020304; in_len = 4;
    cyc();
    in_data = 32'h05060708;
    for (int k = 0; k < 8; k++) begin
      beat($sformatf("b2b%0d", k), 8'(k + 1), 8'(k < 4 ? 4 - k : 12 - k), k % 4, k % 4 == 3);
      if (k == 3) in_valid = 0;
    end
    send(32'h11223344, 4);
    beat("bp0", 8'h11, 8'h44, 0, 0);
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_msb", 32'(out_data_m), 32'h22);
      chk("bp_hold_lsb", 32'(out_data_l), 32'h33);
      chk("bp_hold_idx", 32'(out_idx_m), 1);
      chk("bp_hold_in_ready", 32'(in_ready_m), 0);
      cyc();
    end
    out_ready = 1;
    beat("bp1", 8'h22, 8'h33, 1, 0);
    beat("bp2", 8'h33, 8'h22, 2, 0);
    beat("bp3", 8'h44, 8'h11, 3, 1);
    send(32'hCAFEF00D, 4);
    beat("mr0", 8'hCA, 8'h0D, 0, 0);
    beat("mr1", 8'hFE, 8'hF0, 1, 0);
    reset = 1;
    cyc();
    reset = 0;
    idle_chk("mr_rst", 8'h00, 0, 0);
    chk("mr_rst_lsb", 32'(out_data_l), 0);
    cyc();
    send(32'h0A0B0C0D, 1);
    beat("mr_next", 8'h0A, 8'h0D, 0, 1);
    for (int c = 0; c < 4000; c++) begin
      reset = $urandom_range(0, 149) == 0;
      in_valid = $urandom_range(0, 2) != 0;
      in_data = $urandom;
      in_len = 3'($urandom_range(0, 7));
      out_ready = $urandom_range(0, 3) != 0;
      cyc();
    end
    reset = 0; in_valid = 0; out_ready = 1;
    repeat (6) cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
